mfp_sevenseg_scanner: RTL and testbench

Time-multiplexed scan engine for the eight-digit seven-segment display on the Nexys4-DDR. It sits directly downstream of the AHB seven-segment register slave and consumes that slave's digit-enable, digit-data and decimal-point registers. It drives the board's active-low anode and cathode pins. Each digit gets a fixed time slot, and every slot starts with an anti-ghosting blank interval.

---
 rtl/mfp_sevenseg_pkg.sv | 38 +++
 rtl/mfp_sevenseg_decoder.sv | 18 +
 rtl/mfp_sevenseg_scanner.sv | 95 +++++++++
 tb/tb_mfp_sevenseg_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mfp_sevenseg_pkg.sv
// rtl/mfp_sevenseg_pkg.sv - shared types and segment constants for the seven-segment scanner
package mfp_sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [7:0] GLYPH_DASH = 8'h10;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble
  function automatic logic [6:0] hex_segments(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mfp_sevenseg_decoder.sv
// rtl/mfp_sevenseg_decoder.sv - glyph code to active-low segment pattern
module mfp_sevenseg_decoder
  import mfp_sevenseg_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code[7:4] == 4'h0) begin
      seg = hex_segments(code[3:0]);
    end else if (code == GLYPH_DASH) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/mfp_sevenseg_scanner.sv
// rtl/mfp_sevenseg_scanner.sv - time-multiplexed eight-digit scan engine with per-slot blanking
module mfp_sevenseg_scanner
  import mfp_sevenseg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  EN,
  input  logic [63:0] DIGITS,
  input  logic [7:0]  dp,
  output logic [7:0]  DISPENOUT,
  output logic [7:0]  DISPOUT,
  output logic        FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_SNAP = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic          snap_lit_q, snap_lit_d;
  logic [7:0]    snap_code_q, snap_code_d;
  logic          snap_dp_q, snap_dp_d;
  logic [6:0]    seg;
  logic [7:0]    anode_d, cathode_d;
  logic          frame_d;
  logic          slot_end, snap_now;

  // Decoding the snapshot's next value lets the registered outputs show the
  // freshly sampled digit on the very first SHOW cycle.
  mfp_sevenseg_decoder u_decoder (
    .code (snap_code_d),
    .seg  (seg)
  );

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    snap_now    = (cnt_q == CNT_SNAP);
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = slot_end ? idx_q + 3'd1 : idx_q;
    frame_d     = slot_end && (idx_q == 3'd7);

    snap_lit_d  = snap_lit_q;
    snap_code_d = snap_code_q;
    snap_dp_d   = snap_dp_q;
    if (snap_now) begin
      snap_lit_d  = ~EN[idx_q];
      snap_code_d = DIGITS[{idx_q, 3'b000} +: 8];
      snap_dp_d   = dp[idx_q];
    end

    state_d = state_q;
    case (state_q)
      BLANK:   if (snap_now) state_d = SHOW;
      SHOW:    if (slot_end) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    anode_d   = 8'hFF;
    cathode_d = 8'hFF;
    if ((state_d == SHOW) && snap_lit_d) begin
      anode_d   = ~(8'h01 << idx_q);
      cathode_d = {~snap_dp_d, seg};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      state_q     <= BLANK;
      snap_lit_q  <= 1'b0;
      snap_code_q <= 8'h00;
      snap_dp_q   <= 1'b0;
      DISPENOUT   <= 8'hFF;
      DISPOUT     <= 8'hFF;
      FRAME       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      snap_lit_q  <= snap_lit_d;
      snap_code_q <= snap_code_d;
      snap_dp_q   <= snap_dp_d;
      DISPENOUT   <= anode_d;
      DISPOUT     <= cathode_d;
      FRAME       <= frame_d;
    end
  end

endmodule

// File: tb/tb_mfp_sevenseg_scanner.sv
// tb/tb_mfp_sevenseg_scanner.sv - self-checking bench for the seven-segment scanner
module tb_mfp_sevenseg_scanner;

  localparam int S         = 8;
  localparam int B         = 2;
  localparam int FRAME_LEN = 8 * S;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  EN     = 8'hE0;
  logic [63:0] DIGITS = '0;
  logic [7:0]  dp     = 8'h00;
  logic [7:0]  DISPENOUT;
  logic [7:0]  DISPOUT;
  logic        FRAME;

  mfp_sevenseg_scanner #(
    .SCAN_DIV     (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .EN        (EN),
    .DIGITS    (DIGITS),
    .dp        (dp),
    .DISPENOUT (DISPENOUT),
    .DISPOUT   (DISPOUT),
    .FRAME     (FRAME)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t      = 0;
  int cur    = 0;

  logic [6:0] hex_ref [16];
  logic       m_lit  = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_dp   = 1'b0;
  int         m_pos, m_slot;
  logic [7:0] e_an, e_cat;
  logic [7:0] last_cold = 8'hFF;
  int         ff_run    = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [7:0] c);
    if (c < 8'd16) return hex_ref[c[3:0]];
    if (c == 8'h10) return 7'h3F;
    return 7'h7F;
  endfunction

  // Reference model: slot/position derived from cycles since reset release
  always @(negedge clk) begin
    if (!resetn) begin
      check8("reset_anode", DISPENOUT, 8'hFF);
      check8("reset_cathode", DISPOUT, 8'hFF);
      check8("reset_frame", {7'b0, FRAME}, 8'h00);
      t = 0;
    end else begin
      m_pos  = t % S;
      m_slot = (t / S) % 8;
      if (m_pos == B - 1) begin
        m_lit  = !EN[m_slot];
        m_code = DIGITS[m_slot*8 +: 8];
        m_dp   = dp[m_slot];
      end
      if (m_pos < B) begin
        check8("model_blank_anode", DISPENOUT, 8'hFF);
        check8("model_blank_cathode", DISPOUT, 8'hFF);
      end else if (m_lit) begin
        e_an  = ~(8'h01 << m_slot);
        e_cat = {~m_dp, glyph(m_code)};
        check8("model_show_anode", DISPENOUT, e_an);
        check8("model_show_cathode", DISPOUT, e_cat);
      end else begin
        check8("model_off_anode", DISPENOUT, 8'hFF);
      end
      check8("model_frame", {7'b0, FRAME}, {7'b0, (t > 0) && (t % FRAME_LEN == 0)});
      t++;
    end

    if (DISPENOUT == 8'hFF) begin
      ff_run++;
    end else begin
      if ((last_cold != 8'hFF) && (DISPENOUT != last_cold)) begin
        checks++;
        if (ff_run < B) begin
          errors++;
          $display("FAIL ghost_gap: got %0d blank cycles expected >= %0d at %0t", ff_run, B, $time);
        end
      end
      last_cold = DISPENOUT;
      ff_run    = 0;
    end
  end

  task automatic at(input int k);
    repeat (k - cur) @(posedge clk);
    #1;
    cur = k;
  endtask

  initial begin
    hex_ref[0]  = 7'h40; hex_ref[1]  = 7'h79; hex_ref[2]  = 7'h24; hex_ref[3]  = 7'h30;
    hex_ref[4]  = 7'h19; hex_ref[5]  = 7'h12; hex_ref[6]  = 7'h02; hex_ref[7]  = 7'h78;
    hex_ref[8]  = 7'h00; hex_ref[9]  = 7'h10; hex_ref[10] = 7'h08; hex_ref[11] = 7'h03;
    hex_ref[12] = 7'h46; hex_ref[13] = 7'h21; hex_ref[14] = 7'h06; hex_ref[15] = 7'h0E;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cur = 0;

    // Idle scan: digits 0-4 enabled, all zeros
    check8("c0_anode", DISPENOUT, 8'hFF);
    at(1);   check8("c1_anode", DISPENOUT, 8'hFF);
    at(2);   check8("d0_first_anode", DISPENOUT, 8'hFE);
             check8("d0_first_cathode", DISPOUT, 8'hC0);
    at(7);   check8("d0_last_cathode", DISPOUT, 8'hC0);
    at(8);   check8("slot1_blank_anode", DISPENOUT, 8'hFF);
             check8("slot1_blank_cathode", DISPOUT, 8'hFF);
    at(10);  check8("d1_anode", DISPENOUT, 8'hFD);
    at(43);  check8("d5_off_anode", DISPENOUT, 8'hFF);
    at(63);  check8("frame_before", {7'b0, FRAME}, 8'h00);
    at(64);  check8("frame_pulse", {7'b0, FRAME}, 8'h01);
    at(65);  check8("frame_after", {7'b0, FRAME}, 8'h00);

    // All enabled: 8 / dash / blank code / A with dp
    at(128);
    EN     = 8'h00;
    DIGITS = 64'h0000_0000_0A3C_1008;
    dp     = 8'h08;
    at(130); check8("d0_eight", DISPOUT, 8'h80);
    at(132); DIGITS[7:0] = 8'h01;
    at(135); check8("d0_held_snapshot", DISPOUT, 8'h80);
    at(138); check8("d1_dash_anode", DISPENOUT, 8'hFD);
             check8("d1_dash_cathode", DISPOUT, 8'hBF);
    at(146); check8("d2_blank_anode", DISPENOUT, 8'hFB);
             check8("d2_blank_cathode", DISPOUT, 8'hFF);
    at(154); check8("d3_a_dp_anode", DISPENOUT, 8'hF7);
             check8("d3_a_dp_cathode", DISPOUT, 8'h08);
    at(194); check8("d0_next_anode", DISPENOUT, 8'hFE);
             check8("d0_next_cathode", DISPOUT, 8'hF9);

    // Asynchronous reset during digit 5 SHOW
    at(235); check8("d5_show_anode", DISPENOUT, 8'hDF);
             check8("d5_show_cathode", DISPOUT, 8'hC0);
    resetn = 1'b0;
    #1;
    check8("async_rst_anode", DISPENOUT, 8'hFF);
    check8("async_rst_cathode", DISPOUT, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cur = 0;
    at(1);   check8("rst2_c1_anode", DISPENOUT, 8'hFF);
    at(2);   check8("rst2_d0_anode", DISPENOUT, 8'hFE);
             check8("rst2_d0_cathode", DISPOUT, 8'hF9);
    at(140);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
